// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
//   Shared constants and types for the register-file dump reader.
//   RF_ADDR_W / RF_DATA_W : default register index and data widths (32 GPRs x 32b).
//   rf_dump_state_t       : sweeper FSM encoding (IDLE, FETCH, SEND, CSUM, DONE).
//   CSUM exists in the encoding in every build; it is only reachable when the
//   design is built with RF_DUMP_CSUM_EN defined.
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4
  } rf_dump_state_t;

endpackage : rf_pkg

// File: rtl/rf_dump_csum.sv
// ---------------------------------------------------------------------------
// rf_dump_csum
//   Running XOR of every register word handed to the consumer during a dump.
//   Only instantiated when RF_DUMP_CSUM_EN is defined.
// Ports
//   clk_i      in   core clock
//   reset_n_i  in   synchronous reset, active low
//   clear_i    in   zero the accumulator (dump start accepted)
//   acc_en_i   in   fold data_i into the accumulator (register beat handshake)
//   data_i     in   register word being sent
//   sum_o      out  XOR of all words accumulated since the last clear
// ---------------------------------------------------------------------------
module rf_dump_csum
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  input  logic              acc_en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sum_o
);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sum_o <= '0;
    end else if (clear_i) begin
      sum_o <= '0;
    end else if (acc_en_i) begin
      sum_o <= sum_o ^ data_i;
    end
  end

endmodule : rf_dump_csum

// File: rtl/rf_dump_reader.sv
// ---------------------------------------------------------------------------
// rf_dump_reader
//   Read-side sweeper for the core register file. Walks the wrapping index
//   range [first_addr_i .. last_addr_i] through one combinational RF read port
//   and streams each (addr, data) pair on a valid/ready interface.
//
//   Optional feature macro: RF_DUMP_CSUM_EN
//     defined   : a trailer beat (addr 0, data = XOR of all register words,
//                 last = 1) follows the register beats.
//     undefined : the final register beat carries dump_last_o.
//
// Ports
//   clk_i         in   core clock
//   reset_n_i     in   synchronous reset, active low
//   start_i       in   begin a dump (sampled only while idle)
//   first_addr_i  in   first register index, latched on accepted start
//   last_addr_i   in   last register index, latched on accepted start
//   rf_addr_o     out  RF read address
//   rf_rd_i       in   RF read data for rf_addr_o (same cycle)
//   dump_valid_o  out  output beat valid
//   dump_ready_i  in   consumer ready
//   dump_addr_o   out  register index of current beat
//   dump_data_o   out  register value of current beat
//   dump_last_o   out  final beat of the dump
//   busy_o        out  dump in progress
//   done_o        out  one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module rf_dump_reader
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_rd_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic              done_o
);

`ifdef RF_DUMP_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  rf_dump_state_t    state_q;
  logic [ADDR_W-1:0] last_q;
  logic              at_last;
  logic              handshake;

  assign at_last   = (rf_addr_o == last_q);
  assign handshake = dump_valid_o && dump_ready_i;

`ifdef RF_DUMP_CSUM_EN
  logic [DATA_W-1:0] csum;

  rf_dump_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   ((state_q == ST_IDLE) && start_i),
    .acc_en_i  ((state_q == ST_SEND) && handshake),
    .data_i    (dump_data_o),
    .sum_o     (csum)
  );
`endif

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples pre-edge values; blocking would create ordering races.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      last_q       <= '0;
      rf_addr_o    <= '0;
      dump_valid_o <= 1'b0;
      dump_addr_o  <= '0;
      dump_data_o  <= '0;
      dump_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            last_q    <= last_addr_i;
            rf_addr_o <= first_addr_i;
            busy_o    <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end

        // RF read is combinational, so rf_rd_i already reflects rf_addr_o.
        ST_FETCH: begin
          dump_data_o  <= rf_rd_i;
          dump_addr_o  <= rf_addr_o;
          dump_valid_o <= 1'b1;
          dump_last_o  <= at_last && !CSUM_EN;
          state_q      <= ST_SEND;
        end

        // Beat registers are only touched on handshake, so they hold while stalled.
        ST_SEND: begin
          if (handshake) begin
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
            if (!at_last) begin
              rf_addr_o <= rf_addr_o + ADDR_W'(1);
              state_q   <= ST_FETCH;
            end else begin
`ifdef RF_DUMP_CSUM_EN
              // Trailer carries the XOR including the word just accepted.
              dump_valid_o <= 1'b1;
              dump_addr_o  <= '0;
              dump_data_o  <= csum ^ dump_data_o;
              dump_last_o  <= 1'b1;
              state_q      <= ST_CSUM;
`else
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              state_q <= ST_DONE;
`endif
            end
          end
        end

        ST_CSUM: begin
          if (handshake) begin
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            state_q      <= ST_DONE;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q      <= ST_IDLE;
          dump_valid_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule : rf_dump_reader
